// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: divider state encoding and
// the constants the divider fixup logic compares against.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [4:0]  ITER_LAST = 5'd31;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic           ge;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        // Keeping the carry-out bit in the compare makes trial >= 0 exact.
        ge     = (rem_sh >= {1'b0, dmag_i});
        rem_o  = ge ? (rem_sh[WIDTH-1:0] - dmag_i) : rem_sh[WIDTH-1:0];
        quo_o  = {quo_i[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_divider_32.sv
// Sequential signed restoring divider: one quotient bit per cycle on
// magnitudes, then a single sign-fixup cycle before presenting the result.
module seq_divider_32
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_valid,
    output logic             exception
);

    div_state_e       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             valid_q, valid_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dmag_i (dmag_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    assign ready        = (state_q == IDLE) || (state_q == DONE);
    assign accept       = start && ready;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign result_valid = valid_q;
    assign exception    = exc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        valid_d     = valid_q;
        exc_d       = exc_q;

        case (state_q)
            IDLE, DONE: begin
                // A divide-by-zero lands in DONE with valid low; it rises a cycle later.
                if (state_q == DONE) valid_d = 1'b1;
                if (accept) begin
                    dvd_neg_d = dividend[WIDTH-1];
                    dvs_neg_d = divisor[WIDTH-1];
                    dmag_d    = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
                    quo_d     = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
                    rem_d     = '0;
                    cnt_d     = '0;
                    valid_d   = 1'b0;
                    ovf_d     = (dividend == INT_MIN) && (divisor == '1);
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        exc_d       = 1'b1;
                    end else begin
                        state_d = RUN;
                        exc_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == ITER_LAST) state_d = FIX;
            end
            FIX: begin
                quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? (~quo_q + 1'b1) : quo_q;
                remainder_d = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;
                exc_d       = ovf_q;
                valid_d     = 1'b1;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            valid_q     <= valid_d;
            exc_q       <= exc_d;
        end
    end

endmodule

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: directed corner cases plus random
// operands against a signed-arithmetic reference model.
module tb_seq_divider_32;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        result_valid;
    logic        exception;

    int checks = 0;
    int failures = 0;

    seq_divider_32 #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .ready        (ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .result_valid (result_valid),
        .exception    (exception)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, remainder follows dividend.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q = lq[31:0]; r = lr[31:0]; e = 1'b0;
        end
    endtask

    // Issue one operation (start raised at the negedge before the accept edge)
    // and check latency and results; pulse=1 injects a stray start mid-run.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input bit pulse);
        logic [31:0] eq, er;
        logic        ee;
        int          lat, exp_lat;
        model(a, b, eq, er, ee);
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clock);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        chk({tag, "_rv_low"}, {31'd0, result_valid}, 32'd0);
        lat = 0;
        while (!result_valid && lat < 40) begin
            if (pulse && lat == 10) begin
                @(negedge clock);
                start = 1'b1; dividend = 32'd5; divisor = 32'd1;
                @(posedge clock); #1;
                start = 1'b0;
            end else begin
                @(posedge clock); #1;
            end
            lat++;
            if (lat == 1 && b != 32'd0) chk({tag, "_busy"}, {31'd0, ready}, 32'd0);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_quo"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        chk({tag, "_exc"}, {31'd0, exception}, {31'd0, ee});
        chk({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_quo", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_exc", {31'd0, exception}, 32'd0);
        chk("rst_rdy", {31'd0, ready}, 32'd1);
        @(negedge clock); reset_n = 1'b1;

        // Directed cases
        do_op("p100_7",   32'd100, 32'd7, 1'b0);
        do_op("m100_7",   32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op("p100_m7",  32'd100, 32'hFFFF_FFF9, 1'b0);
        do_op("m100_m7",  32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
        do_op("div0",     32'd12345, 32'd0, 1'b0);
        do_op("min_m1",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("min_1",    32'h8000_0000, 32'd1, 1'b0);
        do_op("max_min",  32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        do_op("min_min",  32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("zero_5",   32'd0, 32'd5, 1'b0);
        do_op("mneg_div0", 32'hFFFF_FF00, 32'd0, 1'b0);
        do_op("stray_go", 32'h0001_869F, 32'h0000_0FFF, 1'b1);

        // Asynchronous reset in the middle of RUN
        @(negedge clock);
        start = 1'b1; dividend = 32'h0001_869F; divisor = 32'h0000_0FFF;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mrst_quo", quotient, 32'd0);
        chk("mrst_rem", remainder, 32'd0);
        chk("mrst_rv", {31'd0, result_valid}, 32'd0);
        chk("mrst_exc", {31'd0, exception}, 32'd0);
        chk("mrst_rdy", {31'd0, ready}, 32'd1);
        @(negedge clock); reset_n = 1'b1;
        do_op("after_rst", 32'd123, 32'd321, 1'b0);

        // Random operands, issued back-to-back from DONE
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = $urandom_range(1, 300);
            if (i % 5 == 2) b = -$urandom_range(1, 300);
            if (i == 7) b = 32'd0;
            do_op("rand", a, b, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
